// File: rtl/ex_stage_if.sv
// ID/EX to EX/MEM bundle for the execute stage: the decoded operands and
// control bits going in, the registered EX/MEM fields, Stall and Busy coming out.
interface ex_stage_if;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        MemWrite_i;
  logic        MemRead_i;
  logic        ALUSrc_i;
  logic        RegDst_i;
  logic [3:0]  ALUOp_i;
  logic [31:0] ReadData1_i;
  logic [31:0] ReadData2_i;
  logic [31:0] SignExtendResult_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;

  logic        Stall_o;
  logic        Busy_o;
  logic [31:0] ALUResultOut_o;
  logic [31:0] WriteDataOut_o;
  logic [4:0]  WriteRegOut_o;
  logic        RegWriteOut_o;
  logic        MemtoRegOut_o;
  logic        MemWriteOut_o;
  logic        MemReadOut_o;

  modport master (
    output RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegDst_i,
           ALUOp_i, ReadData1_i, ReadData2_i, SignExtendResult_i, rt_i, rd_i,
    input  Stall_o, Busy_o, ALUResultOut_o, WriteDataOut_o, WriteRegOut_o,
           RegWriteOut_o, MemtoRegOut_o, MemWriteOut_o, MemReadOut_o
  );

  modport slave (
    input  RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegDst_i,
           ALUOp_i, ReadData1_i, ReadData2_i, SignExtendResult_i, rt_i, rd_i,
    output Stall_o, Busy_o, ALUResultOut_o, WriteDataOut_o, WriteRegOut_o,
           RegWriteOut_o, MemtoRegOut_o, MemWriteOut_o, MemReadOut_o
  );
endinterface

// File: rtl/ex_stage.sv
// Pipeline execute stage: single-cycle ALU feeding the EX/MEM register, plus an
// iterative 32-cycle shift-add unsigned multiplier writing the HI/LO pair.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  ex
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_LUI  = 4'b1011;
  localparam logic [3:0] OP_MULT = 4'b1100;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_MFLO = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] accSum;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] result_q, result_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [3:0]  ctrl_q, ctrl_d;

  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  shamt;
  logic [31:0] aluRes;
  logic        busy;
  logic        stall;

  assign opA   = ex.ReadData1_i;
  assign opB   = ex.ALUSrc_i ? ex.SignExtendResult_i : ex.ReadData2_i;
  assign shamt = ex.SignExtendResult_i[10:6];
  assign busy  = (state_q == BUSY);
  assign stall = busy && ((ex.ALUOp_i == OP_MULT) || (ex.ALUOp_i == OP_MFHI) ||
                          (ex.ALUOp_i == OP_MFLO));

  always_comb begin
    aluRes = '0;
    unique case (ex.ALUOp_i)
      OP_ADD:  aluRes = opA + opB;
      OP_SUB:  aluRes = opA - opB;
      OP_AND:  aluRes = opA & opB;
      OP_OR:   aluRes = opA | opB;
      OP_XOR:  aluRes = opA ^ opB;
      OP_NOR:  aluRes = ~(opA | opB);
      OP_SLT:  aluRes = {31'd0, $signed(opA) < $signed(opB)};
      OP_SLTU: aluRes = {31'd0, opA < opB};
      OP_SLL:  aluRes = opB << shamt;
      OP_SRL:  aluRes = opB >> shamt;
      OP_SRA:  aluRes = $unsigned($signed(opB) >>> shamt);
      OP_LUI:  aluRes = opB << 16;
      OP_MULT: aluRes = '0;
      OP_MFHI: aluRes = hi_q;
      OP_MFLO: aluRes = lo_q;
      OP_PASS: aluRes = opA;
      default: aluRes = '0;
    endcase
  end

  // A stalled cycle inserts a bubble: control cleared, data fields held.
  always_comb begin
    result_d = result_q;
    wdata_d  = wdata_q;
    wreg_d   = wreg_q;
    ctrl_d   = 4'b0000;
    if (!stall) begin
      result_d = aluRes;
      wdata_d  = ex.ReadData2_i;
      wreg_d   = ex.RegDst_i ? ex.rd_i : ex.rt_i;
      if (ex.ALUOp_i != OP_MULT) begin
        ctrl_d = {ex.RegWrite_i, ex.MemtoReg_i, ex.MemWrite_i, ex.MemRead_i};
      end
    end
  end

  assign accSum = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if ((ex.ALUOp_i == OP_MULT) && !stall) begin
          state_d  = BUSY;
          count_d  = 5'd0;
          mcand_d  = {32'd0, opA};
          mplier_d = opB;
          acc_d    = 64'd0;
        end
      end
      BUSY: begin
        acc_d    = accSum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) begin
          hi_d    = accSum[63:32];
          lo_d    = accSum[31:0];
          count_d = 5'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      wreg_q   <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      wreg_q   <= wreg_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ex.Stall_o        = stall;
  assign ex.Busy_o         = busy;
  assign ex.ALUResultOut_o = result_q;
  assign ex.WriteDataOut_o = wdata_q;
  assign ex.WriteRegOut_o  = wreg_q;
  assign ex.RegWriteOut_o  = ctrl_q[3];
  assign ex.MemtoRegOut_o  = ctrl_q[2];
  assign ex.MemWriteOut_o  = ctrl_q[1];
  assign ex.MemReadOut_o   = ctrl_q[0];

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a behavioural model predicts each cycle's Stall
// and EX/MEM contents; separate monitor processes pop and compare them.
module tb_ex_stage;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, SLT = 4'h6, SLTU = 4'h7;
  localparam logic [3:0] SRA = 4'hA, MULTU = 4'hC, MFHI = 4'hD, MFLO = 4'hE;

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [3:0]  ctrl;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .ex(bus.slave));

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  bit   stallQ[$];

  // Model state: remaining busy cycles, the product waiting to land, HI/LO.
  int          busyLeft = 0;
  logic [63:0] pending  = 64'd0;
  logic [31:0] hi = 32'd0, lo = 32'd0;
  exp_t        prevOut = '{default: '0};
  bit          lastStall = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a | b);
      4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: return (a < b) ? 32'd1 : 32'd0;
      4'h8: return b << sh;
      4'h9: return b >> sh;
      4'hA: return $unsigned($signed(b) >>> sh);
      4'hB: return {b[15:0], 16'd0};
      4'hC: return 32'd0;
      4'hD: return hi;
      4'hE: return lo;
      default: return a;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd2,
                               input logic [31:0] se, input logic aluSrc, input logic regDst,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] ctrl);
    logic [31:0] b;
    exp_t e;
    bit s;
    @(negedge clk);
    bus.ALUOp_i = op;               bus.ReadData1_i = a;
    bus.ReadData2_i = rd2;          bus.SignExtendResult_i = se;
    bus.ALUSrc_i = aluSrc;          bus.RegDst_i = regDst;
    bus.rt_i = rt;                  bus.rd_i = rd;
    {bus.RegWrite_i, bus.MemtoReg_i, bus.MemWrite_i, bus.MemRead_i} = ctrl;
    b = aluSrc ? se : rd2;
    s = (busyLeft > 0) && (op == MULTU || op == MFHI || op == MFLO);
    stallQ.push_back(s);
    lastStall = s;
    e = prevOut;
    e.ctrl = 4'b0000;
    if (!s) begin
      e.res  = refAlu(op, a, b, int'(se[10:6]));
      e.wd   = rd2;
      e.wr   = regDst ? rd : rt;
      e.ctrl = (op == MULTU) ? 4'b0000 : ctrl;
    end
    if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) {hi, lo} = pending;
    end else if (op == MULTU) begin
      busyLeft = 32;
      pending  = {32'd0, a} * {32'd0, b};
    end
    e.busy  = (busyLeft > 0);
    prevOut = e;
    expQ.push_back(e);
  endtask

  task automatic simpleOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2, 4'b1000);
  endtask

  // Hold a multiplier-class op until the model says it was accepted.
  task automatic holdOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    do begin
      simpleOp(op, a, b);
      guard++;
    end while (lastStall && guard < 40);
    checkOutput("hold_bound", 32'(lastStall), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("rst_busy", 32'(bus.Busy_o), 32'd0);
    checkOutput("rst_res", bus.ALUResultOut_o, 32'd0);
    checkOutput("rst_wd", bus.WriteDataOut_o, 32'd0);
    checkOutput("rst_ctrl", 32'({bus.RegWriteOut_o, bus.MemtoRegOut_o, bus.MemWriteOut_o,
                                 bus.MemReadOut_o, bus.WriteRegOut_o}), 32'd0);
    busyLeft = 0; pending = 64'd0; hi = 32'd0; lo = 32'd0;
    prevOut = '{default: '0};
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit s;
    forever begin
      @(negedge clk);
      #1;
      if (stallQ.size() > 0) begin
        s = stallQ.pop_front();
        checkOutput("stall", 32'(bus.Stall_o), 32'(s));
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("result", bus.ALUResultOut_o, e.res);
        checkOutput("wdata", bus.WriteDataOut_o, e.wd);
        checkOutput("wreg", 32'(bus.WriteRegOut_o), 32'(e.wr));
        checkOutput("ctrl", 32'({bus.RegWriteOut_o, bus.MemtoRegOut_o, bus.MemWriteOut_o,
                                 bus.MemReadOut_o}), 32'(e.ctrl));
        checkOutput("busy", 32'(bus.Busy_o), 32'(e.busy));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.ALUOp_i = '0; bus.ReadData1_i = '0; bus.ReadData2_i = '0; bus.SignExtendResult_i = '0;
    bus.ALUSrc_i = 1'b0; bus.RegDst_i = 1'b0; bus.rt_i = '0; bus.rd_i = '0;
    {bus.RegWrite_i, bus.MemtoReg_i, bus.MemWrite_i, bus.MemRead_i} = 4'b0000;
    doReset();

    applyStimulus(ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd9, 5'd3, 4'b1000);
    simpleOp(SLT, 32'hFFFF_FFFF, 32'd1);
    simpleOp(SLTU, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(SRA, 32'd0, 32'h8000_0000, 32'd4 << 6, 1'b0, 1'b0, 5'd4, 5'd5, 4'b1100);
    applyStimulus(ADD, 32'h10, 32'd0, 32'hFFFF_FFF0, 1'b1, 1'b0, 5'd7, 5'd8, 4'b0011);

    simpleOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    holdOp(MFHI, 32'd0, 32'd0);
    holdOp(MFLO, 32'd0, 32'd0);
    checkOutput("hi_ff", hi, 32'hFFFF_FFFE);

    simpleOp(MULTU, 32'd3, 32'd4);
    simpleOp(ADD, 32'd100, 32'd23);
    simpleOp(SUB, 32'd100, 32'd123);
    for (int i = 0; i < 10; i++) simpleOp(AND_, $urandom, $urandom);
    holdOp(MFLO, 32'd0, 32'd0);
    checkOutput("lo_12", lo, 32'd12);

    simpleOp(MULTU, 32'd1234, 32'd5678);
    for (int i = 0; i < 9; i++) simpleOp(ADD, i, 32'd1);
    doReset();
    simpleOp(MFLO, 32'd0, 32'd0);

    simpleOp(MULTU, 32'd7, 32'd9);
    simpleOp(ADD, 32'd1, 32'd1);
    holdOp(MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    holdOp(MFHI, 32'd0, 32'd0);
    holdOp(MFLO, 32'd0, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      applyStimulus(op, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom,
                    $urandom, $urandom, 1'($urandom), 1'($urandom),
                    5'($urandom), 5'($urandom), 4'($urandom));
    end

    repeat (3) @(negedge clk);
    checkOutput("drain", 32'(expQ.size() + stallQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
